// File: rtl/demux8_rx.sv
// -----------------------------------------------------------------------------
// demux8_rx
//
// Receive end of the 8:1 mux lane scheme. An upstream 8:1 mux, steered by the
// select `s` driven from this block, serialises one 8-bit word onto `din`, one
// lane per enabled sample. This block locks onto the frame-start marker
// (`sync`, high with the lane-0 bit), reassembles the eight lane bits into `q`
// and flags misplaced frame starts on `err`.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   din    in   serial data bit for the current lane
//   sync   in   frame-start marker, expected together with the lane-0 bit
//   en     in   sample strobe; din/sync are ignored while low
//   s      out  [2:0] lane expected on the next sample (upstream mux select)
//   q      out  [7:0] last complete word, q[i] = lane i
//   valid  out  one-cycle pulse when q updates
//   err    out  one-cycle pulse on a framing error
//
// Handshake: there is no back-pressure. A sample is consumed on every rising
// edge where en=1; valid and err are single-cycle pulses qualified by nothing
// else, and q holds its value until the next valid pulse.
//
// Configuration
//   DEMUX8_STRICT_SYNC_EN  when defined, a LOCK sample at lane 0 without sync
//                          is a framing error that drops the block back to
//                          HUNT. When undefined, sync is only needed to
//                          acquire lock and unmarked lane-0 samples are taken
//                          as ordinary frame starts.
// -----------------------------------------------------------------------------
module demux8_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       sync,
  input  logic       en,
  output logic [2:0] s,
  output logic [7:0] q,
  output logic       valid,
  output logic       err
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  shadow_q, shadow_d;
  logic [7:0]  q_q, q_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  // Current FSM state, kept as a named signal so checkers can bind to it.
  state_e      state_dbg;
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (en) begin
      unique case (state_q)
        HUNT: begin
          // Everything before the first marker is discarded.
          if (sync) begin
            shadow_d[0] = din;
            cnt_d       = 3'd1;
            state_d     = LOCK;
          end
        end

        LOCK: begin
          if (sync && (cnt_q != 3'd0)) begin
            // Marker arrived early: drop the partial word and restart the
            // frame on this sample. Takes priority over the lane-7 emit.
            err_d       = 1'b1;
            shadow_d[0] = din;
            cnt_d       = 3'd1;
`ifdef DEMUX8_STRICT_SYNC_EN
          end else if (!sync && (cnt_q == 3'd0)) begin
            // Lane 0 without its marker: lose lock and discard the sample.
            err_d   = 1'b1;
            cnt_d   = 3'd0;
            state_d = HUNT;
`endif
          end else if (cnt_q == 3'd7) begin
            q_d     = {din, shadow_q};
            valid_d = 1'b1;
            cnt_d   = 3'd0;
          end else begin
            shadow_d[cnt_q] = din;
            cnt_d           = cnt_q + 3'd1;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HUNT;
      cnt_q    <= 3'd0;
      shadow_q <= 7'd0;
      q_q      <= 8'h00;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign s     = cnt_q;
  assign q     = q_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_demux8_rx.sv
// -----------------------------------------------------------------------------
// tb_demux8_rx
//
// Bench for demux8_rx. Stimulus is driven one sample per clock; after each
// rising edge the outputs are compared with a reference model that keeps the
// received lane bits of the current frame in a queue. Emitted words are also
// pushed to an expected-word queue and popped whenever the DUT pulses valid.
// -----------------------------------------------------------------------------
module tb_demux8_rx;

  localparam int W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       sync = 1'b0;
  logic       en = 1'b0;
  logic [2:0] s;
  logic [7:0] q;
  logic       valid;
  logic       err;

  always #5 clk = ~clk;

  demux8_rx dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .sync  (sync),
    .en    (en),
    .s     (s),
    .q     (q),
    .valid (valid),
    .err   (err)
  );

  // ---------------------------------------------------------------- model state
`ifdef DEMUX8_STRICT_SYNC_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  bit         m_locked;
  bit         m_bits[$];        // lane bits of the frame in progress, lane 0 first
  logic [7:0] m_word;           // last emitted word
  logic       m_valid;
  logic       m_err;
  logic [W-1:0] exp_q[$];       // scoreboard: words the DUT still owes

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int valid_cycles[$];
  int err_count = 0;

  // ---------------------------------------------------------------- checks
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge.
  task automatic model_step(input logic e, input logic sy, input logic d, input logic rst);
    logic [7:0] w;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      m_locked = 1'b0;
      m_bits.delete();
      m_word = 8'h00;
    end else if (e) begin
      if (!m_locked) begin
        if (sy) begin
          m_bits.delete();
          m_bits.push_back(d);
          m_locked = 1'b1;
        end
      end else if (sy && m_bits.size() != 0) begin
        m_err = 1'b1;
        m_bits.delete();
        m_bits.push_back(d);
      end else if (STRICT && !sy && m_bits.size() == 0) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == 8) begin
          w = 8'h00;
          for (int i = 0; i < 8; i++) w[i] = m_bits[i];
          m_word  = w;
          m_valid = 1'b1;
          exp_q.push_back(w);
          m_bits.delete();
        end
      end
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step(input logic e, input logic sy, input logic d, input logic rst);
    logic [7:0] exp_s;
    reset = rst;
    en    = e;
    sync  = sy;
    din   = d;
    model_step(e, sy, d, rst);
    @(posedge clk);
    #1;
    cyc++;
    exp_s = 8'(m_bits.size());
    check("s",     {5'd0, s},     exp_s);
    check("q",     q,             m_word);
    check("valid", {7'd0, valid}, {7'd0, m_valid});
    check("err",   {7'd0, err},   {7'd0, m_err});
    if (err === 1'b1) err_count++;
    if (valid === 1'b1) begin
      valid_cycles.push_back(cyc);
      if (exp_q.size() > 0) check("sb_word", q, exp_q.pop_front());
      else check("sb_unexpected_valid", {7'd0, valid}, 8'h00);
    end
  endtask

  task automatic send_frame(input logic [7:0] word, input bit gaps, input bit mark);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, mark && (i == 0), word[i], 1'b0);
      if (gaps) step(1'b0, 1'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    int nv;
    int ne;
    logic e, sy, d, rst;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_s", {5'd0, s}, 8'h00);
    check("rst_q", q, 8'h00);

    // Single word A5, LSB first
    nv = valid_cycles.size();
    send_frame(8'hA5, 1'b0, 1'b1);
    check("a5_q", q, 8'hA5);
    check("a5_valid", {7'd0, valid}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("a5_valid_drop", {7'd0, valid}, 8'h00);
    check("a5_err_none", 8'(err_count), 8'h00);

    // Back-to-back 3C, FF
    nv = valid_cycles.size();
    send_frame(8'h3C, 1'b0, 1'b1);
    check("b2b_q0", q, 8'h3C);
    send_frame(8'hFF, 1'b0, 1'b1);
    check("b2b_q1", q, 8'hFF);
    check("b2b_pulses", 8'(valid_cycles.size() - nv), 8'h02);
    if (valid_cycles.size() - nv == 2)
      check("b2b_gap", 8'(valid_cycles[nv+1] - valid_cycles[nv]), 8'h08);

    // Hunt: unmarked samples after reset are ignored
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'($urandom), 1'b0);
      check("hunt_s", {5'd0, s}, 8'h00);
    end
    send_frame(8'h81, 1'b0, 1'b1);
    check("hunt_q", q, 8'h81);

    // Misplaced sync at cnt=4, then the restarted frame completes 0F
    ne = err_count;
    nv = valid_cycles.size();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) step(1'b1, 1'b0, 1'($urandom), 1'b0);
    check("mis_s4", {5'd0, s}, 8'h04);
    send_frame(8'h0F, 1'b0, 1'b1);
    check("mis_err", 8'(err_count - ne), 8'h01);
    check("mis_one_valid", 8'(valid_cycles.size() - nv), 8'h01);
    check("mis_q", q, 8'h0F);
    check("mis_s0", {5'd0, s}, 8'h00);

    // en toggling through a 5A frame
    send_frame(8'h5A, 1'b1, 1'b1);
    check("gap_q", q, 8'h5A);

    // Reset at cnt=5
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'($urandom), 1'b0);
    check("mid_s5", {5'd0, s}, 8'h05);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("mid_rst_s", {5'd0, s}, 8'h00);
    check("mid_rst_q", q, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("mid_hunt_s", {5'd0, s}, 8'h00);

    // Second frame with no marker on lane 0
    ne = err_count;
    send_frame(8'h5A, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b0);
    if (STRICT) begin
      check("strict_err", 8'(err_count - ne), 8'h01);
      check("strict_q", q, 8'h5A);
    end else begin
      check("loose_err", 8'(err_count - ne), 8'h00);
      check("loose_q", q, 8'hC3);
    end

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      e   = ($urandom_range(0, 3) != 0);
      sy  = ((m_bits.size() == 0) && ($urandom_range(0, 3) != 0)) || ($urandom_range(0, 15) == 0);
      d   = 1'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step(e, sy, d, rst);
    end

    check("sb_drained", 8'(exp_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
